// File: rtl/constants_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : constants_pkg
//  Description : Shared widths and defaults for the fetch/memory stream.
//  Revision    : 1.0  initial release
// ============================================================================
package constants_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;

  localparam int MEM_DEPTH_DEF      = 64;
  localparam int READ_LAT_DEF       = 2;
  localparam int RSP_FIFO_DEPTH_DEF = 4;

  // Data returned for a request whose address lies outside the scratchpad.
  localparam logic [DATA_WIDTH-1:0] OOB_DATA = '0;

  // True when a word address falls inside a scratchpad of the given depth.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr,
                                         input int depth);
    return (int'(addr) < depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rsp_fifo
//  Description : Synchronous first-word-visible FIFO. DEPTH must be a power
//                of two and at least 2. A push and a pop in the same cycle
//                leave occupancy unchanged, including when full or empty
//                (when empty the pushed word bypasses straight to pop_data).
//  Revision    : 1.0  initial release
// ============================================================================
module rsp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Status flags and the pointer moves that the current push/pop imply.
  always_comb begin
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop   = pop && !empty;
    // Empty with push+pop: the word is consumed in flight, nothing is stored.
    do_push  = push && !(empty && pop) && (!full || do_pop);
    wr_d     = do_push ? wr_q + 1'b1 : wr_q;
    rd_d     = do_pop  ? rd_q + 1'b1 : rd_q;
    pop_data = empty ? push_data : mem_q[rd_q[AW-1:0]];
  end

  // Pointer registers; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Scratchpad read responder. Requests are admitted against a
//                credit count equal to the response FIFO depth, so every
//                in-flight read is guaranteed a FIFO slot and the fixed
//                latency read pipeline never has to stall.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_responder
  import constants_pkg::*;
#(
  parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
  parameter int READ_LAT       = READ_LAT_DEF,
  parameter int RSP_FIFO_DEPTH = RSP_FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_vld,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  m_req_vld,
  output logic                  m_req_rdy,
  input  logic [ADDR_WIDTH-1:0] m_req_addr,
  output logic                  m_rsp_vld,
  input  logic                  m_rsp_rdy,
  output logic [DATA_WIDTH-1:0] m_rsp_data,
  output logic                  err_oob,
  output logic                  busy
);

  localparam int                MEM_AW  = $clog2(MEM_DEPTH);
  localparam int                CNT_W   = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RSP_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_oob_q, err_oob_d;
  logic [READ_LAT-1:0]   pipe_vld_q, pipe_vld_d;
  logic [DATA_WIDTH-1:0] pipe_data_q [READ_LAT];
  logic [DATA_WIDTH-1:0] pipe_data_d [READ_LAT];

  logic                  req_fire;
  logic                  rsp_fire;
  logic                  req_ok;
  logic                  ld_ok;

  logic                  fifo_push;
  logic [DATA_WIDTH-1:0] fifo_push_data;
  logic [DATA_WIDTH-1:0] fifo_pop_data;
  logic                  fifo_empty;
  logic                  fifo_full;

  // Handshakes and credit admission; a load cycle always blocks requests so
  // the scratchpad never sees a read and a write in the same cycle.
  always_comb begin
    req_ok     = addr_in_range(m_req_addr, MEM_DEPTH);
    ld_ok      = addr_in_range(ld_addr, MEM_DEPTH);
    m_req_rdy  = !rst && !ld_vld && (cnt_q < CNT_MAX);
    m_rsp_vld  = !fifo_empty;
    m_rsp_data = fifo_empty ? '0 : fifo_pop_data;
    busy       = (cnt_q != '0);
    err_oob    = err_oob_q;
    req_fire   = m_req_vld && m_req_rdy;
    rsp_fire   = m_rsp_vld && m_rsp_rdy;
  end

  // Next-state for credits, sticky error flag and the read shift pipeline.
  always_comb begin
    cnt_d = cnt_q;
    case ({req_fire, rsp_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    err_oob_d = err_oob_q | (ld_vld && !ld_ok) | (req_fire && !req_ok);

    pipe_vld_d     = '0;
    pipe_vld_d[0]  = req_fire;
    pipe_data_d[0] = req_ok ? mem[m_req_addr[MEM_AW-1:0]] : OOB_DATA;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end

    fifo_push      = pipe_vld_q[READ_LAT-1];
    fifo_push_data = pipe_data_q[READ_LAT-1];
  end

  // Control state: credits, error flag and pipeline valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      err_oob_q  <= 1'b0;
      pipe_vld_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      err_oob_q  <= err_oob_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  // Pipeline data carries no reset; only the valids qualify it.
  always_ff @(posedge clk) begin
    pipe_data_q <= pipe_data_d;
  end

  // Host preload port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (ld_vld && ld_ok) begin
      mem[ld_addr[MEM_AW-1:0]] <= ld_data;
    end
  end

  // Credits reserve a slot for every in-flight read, so a writeback into a
  // full FIFO that is not popping at the same time means the credit logic broke.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full && !rsp_fire));
    end
  end

  rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (rsp_fire),
    .pop_data  (fifo_pop_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Directed self-checking bench for mem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_responder;
  import constants_pkg::*;

  localparam int MEM_DEPTH = 64;
  localparam int READ_LAT  = 2;
  localparam int DEPTH     = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ld_vld;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  m_req_vld;
  logic                  m_req_rdy;
  logic [ADDR_WIDTH-1:0] m_req_addr;
  logic                  m_rsp_vld;
  logic                  m_rsp_rdy;
  logic [DATA_WIDTH-1:0] m_rsp_data;
  logic                  err_oob;
  logic                  busy;

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_DEPTH      (MEM_DEPTH),
    .READ_LAT       (READ_LAT),
    .RSP_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_vld     (ld_vld),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .m_req_vld  (m_req_vld),
    .m_req_rdy  (m_req_rdy),
    .m_req_addr (m_req_addr),
    .m_rsp_vld  (m_rsp_vld),
    .m_rsp_rdy  (m_rsp_rdy),
    .m_rsp_data (m_rsp_data),
    .err_oob    (err_oob),
    .busy       (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_WIDTH-1:0] model_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] exp_q [$];
  logic [DATA_WIDTH-1:0] rsp_log [$];
  int  outstanding = 0;
  bit  model_err   = 1'b0;
  int  n_acc = 0;
  int  n_rsp = 0;
  int  cyc   = 0;
  bit  prev_stall = 1'b0;
  logic [DATA_WIDTH-1:0] prev_data = '0;
  int  first_acc_cyc = -1;
  int  first_vld_cyc = -1;
  int  first_rsp_cyc = -1;
  int  last_rsp_cyc  = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just before the edge (inputs were driven at edge+1),
  // score handshakes against the model, then advance to edge+1.
  task automatic clk_cycle();
    bit rf;
    bit sf;
    logic [DATA_WIDTH-1:0] e;
    #1;
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
      model_err   = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      check("req_rdy", m_req_rdy, !ld_vld && (outstanding < DEPTH));
      check("busy", busy, outstanding != 0);
      check("err_oob", err_oob, model_err);
      if (prev_stall) begin
        check("hold_vld", m_rsp_vld, 1'b1);
        check("hold_data", m_rsp_data, prev_data);
      end
      if (m_rsp_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      rf = m_req_vld && m_req_rdy;
      sf = m_rsp_vld && m_rsp_rdy;
      if (sf) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", m_rsp_vld, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", m_rsp_data, e);
          rsp_log.push_back(m_rsp_data);
          outstanding--;
          n_rsp++;
          if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
          last_rsp_cyc = cyc;
        end
      end
      if (rf) begin
        if (int'(m_req_addr) < MEM_DEPTH) exp_q.push_back(model_mem[m_req_addr[5:0]]);
        else begin
          exp_q.push_back('0);
          model_err = 1'b1;
        end
        outstanding++;
        n_acc++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (ld_vld) begin
        if (int'(ld_addr) < MEM_DEPTH) model_mem[ld_addr[5:0]] = ld_data;
        else model_err = 1'b1;
      end
      prev_stall = m_rsp_vld && !m_rsp_rdy;
      prev_data  = m_rsp_data;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold a request until it is accepted (bounded).
  task automatic send_one(input int addr);
    int b;
    b = n_acc;
    m_req_vld  = 1'b1;
    m_req_addr = ADDR_WIDTH'(addr);
    for (int k = 0; k < 50 && n_acc == b; k++) clk_cycle();
    m_req_vld = 1'b0;
    check("send_accepted", n_acc - b, 1);
  endtask

  // Idle the request side until every expected response has returned.
  task automatic drain();
    m_req_vld = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) clk_cycle();
    check("drain_left", exp_q.size(), 0);
    clk_cycle();
    check("drain_busy", busy, 1'b0);
  endtask

  initial begin
    int base;
    int rbase;
    rst = 1'b1; ld_vld = 1'b0; ld_addr = '0; ld_data = '0;
    m_req_vld = 1'b0; m_req_addr = '0; m_rsp_rdy = 1'b0;
    @(posedge clk); #1;
    repeat (3) clk_cycle();

    // Reset state
    check("rst_req_rdy", m_req_rdy, 1'b0);
    check("rst_rsp_vld", m_rsp_vld, 1'b0);
    check("rst_rsp_data", m_rsp_data, 16'h0000);
    check("rst_err_oob", err_oob, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Test 1: preload mem[k] = k+100, then stream reads of 0..7
    ld_vld = 1'b1;
    for (int k = 0; k < MEM_DEPTH; k++) begin
      ld_addr = ADDR_WIDTH'(k);
      ld_data = DATA_WIDTH'(k + 100);
      clk_cycle();
    end
    ld_vld = 1'b0;
    m_rsp_rdy = 1'b1;
    rsp_log.delete();
    first_acc_cyc = -1; first_vld_cyc = -1; first_rsp_cyc = -1;
    for (int k = 0; k < 8; k++) send_one(k);
    drain();
    check("t1_count", rsp_log.size(), 8);
    for (int k = 0; k < 8 && k < rsp_log.size(); k++) check("t1_data", rsp_log[k], 100 + k);
    // Accept edge closes cycle c; response visible READ_LAT edges later.
    check("t1_latency", first_vld_cyc - first_acc_cyc, READ_LAT + 1);
    check("t1_rsp_span", last_rsp_cyc - first_rsp_cyc, 7);

    // Test 2: backpressure limits outstanding to the FIFO depth
    m_rsp_rdy = 1'b0;
    rsp_log.delete();
    base = n_acc;
    m_req_vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      m_req_addr = ADDR_WIDTH'(10 + n_acc - base);
      clk_cycle();
    end
    m_req_vld = 1'b0;
    check("t2_accepted", n_acc - base, 4);
    check("t2_rdy_full", m_req_rdy, 1'b0);
    m_rsp_rdy = 1'b1;
    #1;
    check("t2_rdy_before_pop", m_req_rdy, 1'b0);
    clk_cycle();
    check("t2_rdy_after_pop", m_req_rdy, 1'b1);
    drain();
    check("t2_count", rsp_log.size(), 4);
    for (int k = 0; k < 4 && k < rsp_log.size(); k++) check("t2_data", rsp_log[k], 110 + k);

    // Test 3: out-of-range request in the middle of a stream
    check("t3_err_before", err_oob, 1'b0);
    rsp_log.delete();
    send_one(5);
    send_one(70);
    send_one(6);
    drain();
    check("t3_count", rsp_log.size(), 3);
    if (rsp_log.size() == 3) begin
      check("t3_d0", rsp_log[0], 16'd105);
      check("t3_d1", rsp_log[1], 16'd0);
      check("t3_d2", rsp_log[2], 16'd106);
    end
    repeat (3) clk_cycle();
    check("t3_err_sticky", err_oob, 1'b1);

    // Test 4: load blocks a concurrent request; read-after-load
    rsp_log.delete();
    ld_vld = 1'b1; ld_addr = 8'd3; ld_data = 16'hABCD;
    m_req_vld = 1'b1; m_req_addr = 8'd3;
    #1;
    check("t4_rdy_during_load", m_req_rdy, 1'b0);
    base = n_acc;
    clk_cycle();
    check("t4_no_accept", n_acc - base, 0);
    ld_vld = 1'b0;
    send_one(3);
    drain();
    check("t4_count", rsp_log.size(), 1);
    if (rsp_log.size() == 1) check("t4_data", rsp_log[0], 16'hABCD);

    // Test 5: reset with responses pending
    m_rsp_rdy = 1'b0;
    send_one(20);
    send_one(21);
    send_one(22);
    repeat (3) clk_cycle();
    check("t5_vld_pending", m_rsp_vld, 1'b1);
    rst = 1'b1;
    clk_cycle();
    check("t5_rst_vld", m_rsp_vld, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_err", err_oob, 1'b0);
    check("t5_rst_data", m_rsp_data, 16'h0000);
    rst = 1'b0;
    m_rsp_rdy = 1'b1;
    rsp_log.delete();
    send_one(1);
    drain();
    repeat (4) clk_cycle();
    check("t5_count", rsp_log.size(), 1);
    if (rsp_log.size() == 1) check("t5_data", rsp_log[0], 16'd101);

    // Test 6: random valid/ready toggling with occasional loads
    base  = n_acc;
    rbase = n_rsp;
    for (int c = 0; c < 20000 && ((n_acc - base) < 500 || exp_q.size() != 0); c++) begin
      m_req_vld  = ((n_acc - base) < 500) && ($urandom_range(0, 3) != 0);
      m_req_addr = ADDR_WIDTH'($urandom_range(0, 71));
      m_rsp_rdy  = ($urandom_range(0, 2) != 0);
      ld_vld     = ($urandom_range(0, 9) == 0);
      ld_addr    = ADDR_WIDTH'($urandom_range(0, 66));
      ld_data    = DATA_WIDTH'($urandom);
      clk_cycle();
    end
    ld_vld = 1'b0;
    m_req_vld = 1'b0;
    m_rsp_rdy = 1'b1;
    check("t6_accepted", n_acc - base, 500);
    check("t6_responses", n_rsp - rbase, 500);
    check("t6_left", exp_q.size(), 0);
    clk_cycle();
    check("t6_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
